multicycle_cu: RTL and testbench

Multicycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5 cycles plus memory wait states. It drives the shared-memory datapath: PC/IR/ALUOut registers, a single ALU, and one unified instruction/data memory with a ready handshake. It generalises single-cycle decoding with variable memory latency, a watchdog timeout and illegal-opcode reporting.

---
 rtl/multicycle_cu_pkg.sv | 46 ++++
 rtl/multicycle_cu_alu_decoder.sv | 29 ++
 rtl/multicycle_cu.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_cu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, ALUOp,
// opcodes, funct fields and ALU control codes.
package multicycle_cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_cu_alu_decoder.sv
// ALU decoder: maps the FSM's 2-bit ALUOp plus the R-type funct field onto
// the 3-bit ALU control code. Unknown funct values fall back to add.
module multicycle_cu_alu_decoder
  import multicycle_cu_pkg::*;
(
  input  aluop_e     alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle MIPS control unit: Moore FSM with memory-ready handshake,
// watchdog abort and illegal-opcode pulse. Define CU_BNE_EN to add BNE.
module multicycle_cu
  import multicycle_cu_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic                 IllegalOp,
  output logic                 MemErr
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             mem_state;
  logic             timeout_hit;

  logic       mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  aluop_e     alu_op;
  logic [2:0] alu_ctrl;

`ifdef CU_BNE_EN
  logic bne_q, bne_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

`ifdef CU_BNE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bne_q <= 1'b0;
    else     bne_q <= bne_d;
  end

  always_comb begin
    bne_d = bne_q;
    if (state_q == S_DECODE) bne_d = (Opcode == OP_BNE);
  end
`endif

  // A ready in the same cycle as the last allowed wait wins over the abort.
  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);
  assign timeout_hit = (TIMEOUT != 0) && mem_state && !MemReady &&
                       (wd_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (MemReady) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef CU_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (MemReady)         state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (MemReady || timeout_hit) state_d = S_FETCH;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
`ifdef CU_BNE_EN
        pc_en     = Zero ^ bne_q;
`else
        pc_en     = Zero;
`endif
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // An abort from FETCH stays in FETCH, so the counter is cleared explicitly.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if ((state_d != state_q) || timeout_hit) wd_cnt_d = '0;
    else if (mem_req && !MemReady)           wd_cnt_d = wd_cnt_q + CNT_W'(1);
  end

  multicycle_cu_alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct    (Funct),
    .alu_ctrl (alu_ctrl)
  );

  always_comb begin
    MemReq     = mem_req    & ~rst;
    MemWrite   = mem_write  & ~rst;
    IorD       = iord       & ~rst;
    IRWrite    = ir_write   & ~rst;
    RegDst     = reg_dst    & ~rst;
    MemtoReg   = mem_to_reg & ~rst;
    RegWrite   = reg_write  & ~rst;
    ALUSrcA    = alu_src_a  & ~rst;
    ALUSrcB    = rst ? 2'b00 : alu_src_b;
    ALUControl = rst ? '0 : ALUCTRL_W'(alu_ctrl);
    PCSrc      = rst ? 2'b00 : pc_src;
    PCEn       = pc_en      & ~rst;
    IllegalOp  = illegal_op & ~rst;
    MemErr     = timeout_hit & ~rst;
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu (TIMEOUT=4): directed per-cycle vectors
// push expected outputs; a negedge monitor pops and compares them.
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;

  logic       MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, IllegalOp, MemErr;

  typedef struct packed {
    logic       memReq, memWrite, iorD, irWrite, regDst, memtoReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluCtrl;
    logic [1:0] pcSrc;
    logic       pcEn, illegalOp, memErr;
  } outVec_t;

  typedef struct {
    outVec_t exp;
    string   tag;
  } sbEntry_t;

  sbEntry_t sb[$];
  sbEntry_t monEntry;
  int errors = 0;
  int checks = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  multicycle_cu #(.ALUCTRL_W(3), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .Opcode(opcode), .Funct(funct), .Zero(zero),
    .MemReady(memReady), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .PCEn(PCEn), .IllegalOp(IllegalOp), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  function automatic outVec_t vBase();
    outVec_t v = '0;
    v.aluCtrl = 3'b010;
    return v;
  endfunction

  function automatic outVec_t vReset();
    return '0;
  endfunction

  function automatic outVec_t vFetch(input logic rdy, input logic err);
    outVec_t v = vBase();
    v.memReq = 1'b1; v.aluSrcB = 2'b01; v.irWrite = rdy; v.pcEn = rdy; v.memErr = err;
    return v;
  endfunction

  function automatic outVec_t vDecode(input logic ill);
    outVec_t v = vBase();
    v.aluSrcB = 2'b11; v.illegalOp = ill;
    return v;
  endfunction

  function automatic outVec_t vMemAdr();
    outVec_t v = vBase();
    v.aluSrcA = 1'b1; v.aluSrcB = 2'b10;
    return v;
  endfunction

  function automatic outVec_t vMemRead();
    outVec_t v = vBase();
    v.memReq = 1'b1; v.iorD = 1'b1;
    return v;
  endfunction

  function automatic outVec_t vMemWrite(input logic err);
    outVec_t v = vBase();
    v.memReq = 1'b1; v.memWrite = 1'b1; v.iorD = 1'b1; v.memErr = err;
    return v;
  endfunction

  function automatic outVec_t vMemWb();
    outVec_t v = vBase();
    v.regWrite = 1'b1; v.memtoReg = 1'b1;
    return v;
  endfunction

  function automatic outVec_t vExecute(input logic [2:0] ctrl);
    outVec_t v = vBase();
    v.aluSrcA = 1'b1; v.aluCtrl = ctrl;
    return v;
  endfunction

  function automatic outVec_t vAluWb();
    outVec_t v = vBase();
    v.regWrite = 1'b1; v.regDst = 1'b1;
    return v;
  endfunction

  function automatic outVec_t vBranch(input logic pcen);
    outVec_t v = vBase();
    v.aluSrcA = 1'b1; v.aluCtrl = 3'b110; v.pcSrc = 2'b01; v.pcEn = pcen;
    return v;
  endfunction

  function automatic outVec_t vAddiEx();
    outVec_t v = vBase();
    v.aluSrcA = 1'b1; v.aluSrcB = 2'b10;
    return v;
  endfunction

  function automatic outVec_t vAddiWb();
    outVec_t v = vBase();
    v.regWrite = 1'b1;
    return v;
  endfunction

  function automatic outVec_t vJump();
    outVec_t v = vBase();
    v.pcSrc = 2'b10; v.pcEn = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy, input outVec_t e,
                               input string tag);
    sbEntry_t ent;
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct = fn; zero = z; memReady = rdy;
    ent.exp = e;
    ent.tag = tag;
    sb.push_back(ent);
  endtask

  task automatic checkOutput(input outVec_t e, input string tag);
    outVec_t act;
    act = {MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, IllegalOp, MemErr};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, act, e);
    end
  endtask

  // Monitor: compares whatever the DUT presents on the falling edge against the queue head.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      monEntry = sb.pop_front();
      checkOutput(monEntry.exp, monEntry.tag);
    end
  end

  initial begin
    applyStimulus(1, RT, 6'b0, 0, 1, vReset(), "reset0");
    applyStimulus(1, RT, 6'b0, 0, 1, vReset(), "reset1");

    applyStimulus(0, LW, 6'b0, 0, 1, vFetch(1, 0), "lw_fetch");
    applyStimulus(0, LW, 6'b0, 0, 1, vDecode(0), "lw_decode");
    applyStimulus(0, LW, 6'b0, 0, 1, vMemAdr(), "lw_memadr");
    applyStimulus(0, LW, 6'b0, 0, 1, vMemRead(), "lw_memread");
    applyStimulus(0, LW, 6'b0, 0, 1, vMemWb(), "lw_memwb");

    for (int i = 0; i < 3; i++)
      applyStimulus(0, RT, 6'b100010, 0, 0, vFetch(0, 0), "sub_fetch_wait");
    applyStimulus(0, RT, 6'b100010, 0, 1, vFetch(1, 0), "sub_fetch_done");
    applyStimulus(0, RT, 6'b100010, 0, 0, vDecode(0), "sub_decode");
    applyStimulus(0, RT, 6'b100010, 0, 0, vExecute(3'b110), "sub_execute");
    applyStimulus(0, RT, 6'b100010, 0, 0, vAluWb(), "sub_aluwb");

    applyStimulus(0, RT, 6'b101010, 0, 1, vFetch(1, 0), "slt_fetch");
    applyStimulus(0, RT, 6'b101010, 0, 1, vDecode(0), "slt_decode");
    applyStimulus(0, RT, 6'b101010, 0, 1, vExecute(3'b111), "slt_execute");
    applyStimulus(0, RT, 6'b101010, 0, 1, vAluWb(), "slt_aluwb");

    applyStimulus(0, BEQ, 6'b0, 1, 1, vFetch(1, 0), "beq1_fetch");
    applyStimulus(0, BEQ, 6'b0, 1, 1, vDecode(0), "beq1_decode");
    applyStimulus(0, BEQ, 6'b0, 1, 1, vBranch(1), "beq1_branch");
    applyStimulus(0, BEQ, 6'b0, 0, 1, vFetch(1, 0), "beq0_fetch");
    applyStimulus(0, BEQ, 6'b0, 0, 1, vDecode(0), "beq0_decode");
    applyStimulus(0, BEQ, 6'b0, 0, 1, vBranch(0), "beq0_branch");

    for (int z = 1; z >= 0; z--) begin
      applyStimulus(0, BNE, 6'b0, z[0], 1, vFetch(1, 0), "bne_fetch");
`ifdef CU_BNE_EN
      applyStimulus(0, BNE, 6'b0, z[0], 1, vDecode(0), "bne_decode");
      applyStimulus(0, BNE, 6'b0, z[0], 1, vBranch(~z[0]), "bne_branch");
`else
      applyStimulus(0, BNE, 6'b0, z[0], 1, vDecode(1), "bne_illegal");
`endif
    end

    applyStimulus(0, BAD, 6'b0, 0, 1, vFetch(1, 0), "bad_fetch");
    applyStimulus(0, BAD, 6'b0, 0, 1, vDecode(1), "bad_decode");

    applyStimulus(0, ADDI, 6'b0, 0, 1, vFetch(1, 0), "addi_fetch");
    applyStimulus(0, ADDI, 6'b0, 0, 1, vDecode(0), "addi_decode");
    applyStimulus(0, ADDI, 6'b0, 0, 1, vAddiEx(), "addi_ex");
    applyStimulus(0, ADDI, 6'b0, 0, 1, vAddiWb(), "addi_wb");

    applyStimulus(0, JMP, 6'b0, 0, 1, vFetch(1, 0), "j_fetch");
    applyStimulus(0, JMP, 6'b0, 0, 1, vDecode(0), "j_decode");
    applyStimulus(0, JMP, 6'b0, 0, 1, vJump(), "j_jump");

    applyStimulus(0, SW, 6'b0, 0, 1, vFetch(1, 0), "swto_fetch");
    applyStimulus(0, SW, 6'b0, 0, 0, vDecode(0), "swto_decode");
    applyStimulus(0, SW, 6'b0, 0, 0, vMemAdr(), "swto_memadr");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, SW, 6'b0, 0, 0, vMemWrite(0), "swto_wait");
    applyStimulus(0, SW, 6'b0, 0, 0, vMemWrite(1), "swto_memerr");
    applyStimulus(0, SW, 6'b0, 0, 1, vFetch(1, 0), "swto_refetch");

    applyStimulus(0, SW, 6'b0, 0, 0, vDecode(0), "swok_decode");
    applyStimulus(0, SW, 6'b0, 0, 0, vMemAdr(), "swok_memadr");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, SW, 6'b0, 0, 0, vMemWrite(0), "swok_wait");
    applyStimulus(0, SW, 6'b0, 0, 1, vMemWrite(0), "swok_ready_wins");

    for (int i = 0; i < 3; i++)
      applyStimulus(0, JMP, 6'b0, 0, 0, vFetch(0, 0), "fto_wait");
    applyStimulus(0, JMP, 6'b0, 0, 0, vFetch(0, 1), "fto_memerr");
    applyStimulus(0, JMP, 6'b0, 0, 0, vFetch(0, 0), "fto_retry_wait");
    applyStimulus(0, JMP, 6'b0, 0, 1, vFetch(1, 0), "fto_retry_done");
    applyStimulus(0, JMP, 6'b0, 0, 1, vDecode(0), "fto_decode");
    applyStimulus(0, JMP, 6'b0, 0, 1, vJump(), "fto_jump");

    applyStimulus(0, SW, 6'b0, 0, 1, vFetch(1, 0), "swrst_fetch");
    applyStimulus(0, SW, 6'b0, 0, 0, vDecode(0), "swrst_decode");
    applyStimulus(0, SW, 6'b0, 0, 0, vMemAdr(), "swrst_memadr");
    applyStimulus(0, SW, 6'b0, 0, 0, vMemWrite(0), "swrst_wait");
    applyStimulus(1, SW, 6'b0, 0, 0, vReset(), "swrst_abort");
    applyStimulus(1, SW, 6'b0, 0, 0, vReset(), "swrst_hold");
    applyStimulus(0, SW, 6'b0, 0, 0, vFetch(0, 0), "swrst_first_fetch");
    applyStimulus(0, SW, 6'b0, 0, 1, vFetch(1, 0), "swrst_fetch_done");
    applyStimulus(0, SW, 6'b0, 0, 1, vDecode(0), "swrst_decode2");

    begin
      int n = 0;
      while (sb.size() != 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      #1;
      if (sb.size() != 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
